mem_axi_arbiter: RTL and testbench

MEM_AXI_ARBITER -- requirements
Module: mem_axi_arbiter

---
 rtl/renode_memory_pkg.sv | 53 +++++
 rtl/mem_axi_rr_pick.sv | 27 ++
 rtl/mem_axi_arbiter.sv | 174 +++++++++++++++++
 tb/tb_mem_axi_arbiter.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/renode_memory_pkg.sv
// Shared AXI types and FSM state encodings for the renode memory arbiter.
// Field widths are fixed here so every requester, the arbiter and the
// memory-side port agree on one struct layout.
package renode_memory_pkg;

  localparam int AXI_ID_W   = 4;
  localparam int AXI_ADDR_W = 32;
  localparam int AXI_DATA_W = 32;
  localparam int AXI_STRB_W = AXI_DATA_W / 8;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  // Manager -> subordinate direction (AW, W, B-ready, AR, R-ready)
  typedef struct packed {
    logic                  aw_valid;
    logic [AXI_ID_W-1:0]   aw_id;
    logic [AXI_ADDR_W-1:0] aw_addr;
    logic [7:0]            aw_len;
    logic [2:0]            aw_size;
    logic [1:0]            aw_burst;
    logic                  w_valid;
    logic [AXI_DATA_W-1:0] w_data;
    logic [AXI_STRB_W-1:0] w_strb;
    logic                  w_last;
    logic                  b_ready;
    logic                  ar_valid;
    logic [AXI_ID_W-1:0]   ar_id;
    logic [AXI_ADDR_W-1:0] ar_addr;
    logic [7:0]            ar_len;
    logic [2:0]            ar_size;
    logic [1:0]            ar_burst;
    logic                  r_ready;
  } axi_req_t;

  // Subordinate -> manager direction
  typedef struct packed {
    logic                  aw_ready;
    logic                  w_ready;
    logic                  b_valid;
    logic [AXI_ID_W-1:0]   b_id;
    logic [1:0]            b_resp;
    logic                  ar_ready;
    logic                  r_valid;
    logic [AXI_ID_W-1:0]   r_id;
    logic [AXI_DATA_W-1:0] r_data;
    logic [1:0]            r_resp;
    logic                  r_last;
  } axi_resp_t;

  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} w_state_e;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA}         r_state_e;

endpackage

// File: rtl/mem_axi_rr_pick.sv
// Round-robin picker: returns the one-hot index of the first asserted
// request found when searching upward from ptr, wrapping at NUM_REQ.
//   req : request vector
//   ptr : search start index
//   gnt : one-hot winner, all-zero when no request
module mem_axi_rr_pick #(
  parameter  int NUM_REQ = 2,
  localparam int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt
);

  // Walk from farthest to nearest candidate; the nearest hit overwrites.
  always_comb begin
    int k;
    k   = 0;
    gnt = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      k = int'(ptr) + i;
      if (k >= NUM_REQ) k = k - NUM_REQ;
      if (req[k]) gnt = NUM_REQ'(1) << k;
    end
  end

endmodule

// File: rtl/mem_axi_arbiter.sv
// N:1 AXI arbiter in front of the shared renode memory port. Write and read
// paths each own an FSM and a round-robin pointer and run independently, so
// one write and one read can be in flight together. Payload is muxed
// combinationally from the owning requester; only valid/ready are gated.
//   clk_i, rst_ni : clock, async active-low reset
//   slv_req_i     : per-requester AXI requests
//   slv_resp_o    : per-requester AXI responses
//   mst_req_o     : request toward shared memory
//   mst_resp_i    : response from shared memory
//   wr_gnt_o      : one-hot write owner (0 when idle)
//   rd_gnt_o      : one-hot read owner (0 when idle)
//   wlast_err_o   : W beat whose wlast disagrees with awlen
module mem_axi_arbiter
  import renode_memory_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 4   // significant ID bits; must not exceed AXI_ID_W
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  axi_req_t  [NUM_REQ-1:0]  slv_req_i,
  output axi_resp_t [NUM_REQ-1:0]  slv_resp_o,
  output axi_req_t                 mst_req_o,
  input  axi_resp_t                mst_resp_i,
  output logic      [NUM_REQ-1:0]  wr_gnt_o,
  output logic      [NUM_REQ-1:0]  rd_gnt_o,
  output logic                     wlast_err_o
);

  localparam int PTR_W = $clog2(NUM_REQ);

  w_state_e w_state_q, w_state_d;
  r_state_e r_state_q, r_state_d;

  logic [NUM_REQ-1:0] w_gnt_q, r_gnt_q, w_pick, r_pick, aw_vld, ar_vld;
  logic [PTR_W-1:0]   w_ptr_q, r_ptr_q, w_idx, r_idx;
  logic [7:0]         awlen_q, beat_cnt_q;
  logic               aw_hs, w_hs, b_hs, ar_hs, r_hs;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_vld
    assign aw_vld[g] = slv_req_i[g].aw_valid;
    assign ar_vld[g] = slv_req_i[g].ar_valid;
  end

  mem_axi_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick_w (.req(aw_vld), .ptr(w_ptr_q), .gnt(w_pick));
  mem_axi_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick_r (.req(ar_vld), .ptr(r_ptr_q), .gnt(r_pick));

  // Owner index for the payload muxes; 0 when idle, valids are gated anyway.
  always_comb begin
    w_idx = '0;
    r_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_gnt_q[i]) w_idx = PTR_W'(i);
      if (r_gnt_q[i]) r_idx = PTR_W'(i);
    end
  end

  assign aw_hs = (w_state_q == W_ADDR) && slv_req_i[w_idx].aw_valid && mst_resp_i.aw_ready;
  assign w_hs  = (w_state_q == W_DATA) && slv_req_i[w_idx].w_valid  && mst_resp_i.w_ready;
  assign b_hs  = (w_state_q == W_RESP) && mst_resp_i.b_valid && slv_req_i[w_idx].b_ready;
  assign ar_hs = (r_state_q == R_ADDR) && slv_req_i[r_idx].ar_valid && mst_resp_i.ar_ready;
  assign r_hs  = (r_state_q == R_DATA) && mst_resp_i.r_valid && slv_req_i[r_idx].r_ready;

  // ---------------- write FSM ----------------
  always_comb begin
    w_state_d = w_state_q;
    case (w_state_q)
      W_IDLE:  if (|aw_vld) w_state_d = W_ADDR;
      W_ADDR:  if (aw_hs) w_state_d = W_DATA;
      W_DATA:  if (w_hs && slv_req_i[w_idx].w_last) w_state_d = W_RESP;
      W_RESP:  if (b_hs) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  // ---------------- read FSM ----------------
  always_comb begin
    r_state_d = r_state_q;
    case (r_state_q)
      R_IDLE:  if (|ar_vld) r_state_d = R_ADDR;
      R_ADDR:  if (ar_hs) r_state_d = R_DATA;
      R_DATA:  if (r_hs && mst_resp_i.r_last) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      w_state_q <= W_IDLE;
      r_state_q <= R_IDLE;
    end else begin
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
    end
  end

  // Grants, pointers and beat tracking
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      w_gnt_q    <= '0;
      r_gnt_q    <= '0;
      w_ptr_q    <= '0;
      r_ptr_q    <= '0;
      awlen_q    <= '0;
      beat_cnt_q <= '0;
    end else begin
      if (w_state_q == W_IDLE && |aw_vld) w_gnt_q <= w_pick;
      if (b_hs) begin
        w_gnt_q <= '0;
        w_ptr_q <= (int'(w_idx) == NUM_REQ - 1) ? '0 : w_idx + 1'b1;
      end
      if (aw_hs) begin
        awlen_q    <= slv_req_i[w_idx].aw_len;
        beat_cnt_q <= '0;
      end else if (w_hs) begin
        beat_cnt_q <= beat_cnt_q + 8'd1;
      end

      if (r_state_q == R_IDLE && |ar_vld) r_gnt_q <= r_pick;
      if (r_hs && mst_resp_i.r_last) begin
        r_gnt_q <= '0;
        r_ptr_q <= (int'(r_idx) == NUM_REQ - 1) ? '0 : r_idx + 1'b1;
      end
    end
  end

  // Flags a beat whose wlast is set early, or missing on the final beat.
  assign wlast_err_o = w_hs && (slv_req_i[w_idx].w_last != (beat_cnt_q == awlen_q));

  assign wr_gnt_o = w_gnt_q;
  assign rd_gnt_o = r_gnt_q;

  // Memory-side request: payload always muxed from owner, valids per state.
  always_comb begin
    mst_req_o          = '0;
    mst_req_o.aw_id    = AXI_ID_W'(slv_req_i[w_idx].aw_id[ID_W-1:0]);
    mst_req_o.aw_addr  = slv_req_i[w_idx].aw_addr;
    mst_req_o.aw_len   = slv_req_i[w_idx].aw_len;
    mst_req_o.aw_size  = slv_req_i[w_idx].aw_size;
    mst_req_o.aw_burst = slv_req_i[w_idx].aw_burst;
    mst_req_o.w_data   = slv_req_i[w_idx].w_data;
    mst_req_o.w_strb   = slv_req_i[w_idx].w_strb;
    mst_req_o.w_last   = slv_req_i[w_idx].w_last;
    mst_req_o.ar_id    = AXI_ID_W'(slv_req_i[r_idx].ar_id[ID_W-1:0]);
    mst_req_o.ar_addr  = slv_req_i[r_idx].ar_addr;
    mst_req_o.ar_len   = slv_req_i[r_idx].ar_len;
    mst_req_o.ar_size  = slv_req_i[r_idx].ar_size;
    mst_req_o.ar_burst = slv_req_i[r_idx].ar_burst;
    mst_req_o.aw_valid = (w_state_q == W_ADDR) && slv_req_i[w_idx].aw_valid;
    mst_req_o.w_valid  = (w_state_q == W_DATA) && slv_req_i[w_idx].w_valid;
    mst_req_o.b_ready  = (w_state_q == W_RESP) && slv_req_i[w_idx].b_ready;
    mst_req_o.ar_valid = (r_state_q == R_ADDR) && slv_req_i[r_idx].ar_valid;
    mst_req_o.r_ready  = (r_state_q == R_DATA) && slv_req_i[r_idx].r_ready;
  end

  // Requester-side responses: payload broadcast, handshakes only to owner.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      slv_resp_o[i]          = '0;
      slv_resp_o[i].b_id     = AXI_ID_W'(mst_resp_i.b_id[ID_W-1:0]);
      slv_resp_o[i].b_resp   = mst_resp_i.b_resp;
      slv_resp_o[i].r_id     = AXI_ID_W'(mst_resp_i.r_id[ID_W-1:0]);
      slv_resp_o[i].r_data   = mst_resp_i.r_data;
      slv_resp_o[i].r_resp   = mst_resp_i.r_resp;
      slv_resp_o[i].r_last   = mst_resp_i.r_last;
      slv_resp_o[i].aw_ready = w_gnt_q[i] && (w_state_q == W_ADDR) && mst_resp_i.aw_ready;
      slv_resp_o[i].w_ready  = w_gnt_q[i] && (w_state_q == W_DATA) && mst_resp_i.w_ready;
      slv_resp_o[i].b_valid  = w_gnt_q[i] && (w_state_q == W_RESP) && mst_resp_i.b_valid;
      slv_resp_o[i].ar_ready = r_gnt_q[i] && (r_state_q == R_ADDR) && mst_resp_i.ar_ready;
      slv_resp_o[i].r_valid  = r_gnt_q[i] && (r_state_q == R_DATA) && mst_resp_i.r_valid;
    end
  end

endmodule

// File: tb/tb_mem_axi_arbiter.sv
// Directed bench for mem_axi_arbiter (NUM_REQ=2): a cycle table of
// {inputs, expected handshake outputs} plus hand sequences for payload
// pass-through, read-back and asynchronous reset mid-burst.
module tb_mem_axi_arbiter;
  import renode_memory_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  axi_req_t  [1:0] slv_req;
  axi_resp_t [1:0] slv_resp;
  axi_req_t        mst_req;
  axi_resp_t       mst_resp;
  logic [1:0]      wr_gnt, rd_gnt;
  logic            wlast_err;

  mem_axi_arbiter #(.NUM_REQ(2), .ID_W(4)) dut (
    .clk_i(clk), .rst_ni(rst_n), .slv_req_i(slv_req), .slv_resp_o(slv_resp),
    .mst_req_o(mst_req), .mst_resp_i(mst_resp), .wr_gnt_o(wr_gnt),
    .rd_gnt_o(rd_gnt), .wlast_err_o(wlast_err));

  always #5 clk = ~clk;

  // per-port bits are [port]
  typedef struct packed {
    logic [1:0] awv, wv, wl, bry, arv, rry;
    logic       m_awr, m_wr, m_bv, m_arr, m_rv, m_rl;
    logic [1:0] len;
  } in_t;

  typedef struct packed {
    logic [1:0] wgnt, rgnt;
    logic       awv, wv, bry, arv, rry;   // mst_req valids/readies
    logic [1:0] awr, wr, bv, arr, rv;     // per-port slv_resp handshakes
    logic       err;
  } exp_t;

  typedef struct {
    bit    rst;
    in_t   i;
    exp_t  e;
    string nm;
  } vec_t;

  localparam bit H = 1'b1;
  localparam bit L = 1'b0;

  vec_t tbl[$];
  exp_t Z;
  int   n_vec = 0;
  int   n_bad = 0;
  logic [31:0] mem_word;

  function automatic void add(input string nm, input bit r, input in_t i, input exp_t e);
    vec_t v;
    v.rst = r; v.i = i; v.e = e; v.nm = nm;
    tbl.push_back(v);
  endfunction

  function automatic exp_t sample();
    exp_t a;
    a.wgnt = wr_gnt;           a.rgnt = rd_gnt;
    a.awv  = mst_req.aw_valid; a.wv   = mst_req.w_valid;
    a.bry  = mst_req.b_ready;  a.arv  = mst_req.ar_valid;
    a.rry  = mst_req.r_ready;  a.err  = wlast_err;
    for (int p = 0; p < 2; p++) begin
      a.awr[p] = slv_resp[p].aw_ready;
      a.wr[p]  = slv_resp[p].w_ready;
      a.bv[p]  = slv_resp[p].b_valid;
      a.arr[p] = slv_resp[p].ar_ready;
      a.rv[p]  = slv_resp[p].r_valid;
    end
    return a;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic clear();
    slv_req  = '0;
    mst_resp = '0;
  endtask

  task automatic apply(input in_t v);
    for (int p = 0; p < 2; p++) begin
      slv_req[p].aw_valid = v.awv[p];
      slv_req[p].aw_len   = {6'b0, v.len};
      slv_req[p].w_valid  = v.wv[p];
      slv_req[p].w_last   = v.wl[p];
      slv_req[p].b_ready  = v.bry[p];
      slv_req[p].ar_valid = v.arv[p];
      slv_req[p].ar_len   = {6'b0, v.len};
      slv_req[p].r_ready  = v.rry[p];
    end
    mst_resp.aw_ready = v.m_awr;
    mst_resp.w_ready  = v.m_wr;
    mst_resp.b_valid  = v.m_bv;
    mst_resp.ar_ready = v.m_arr;
    mst_resp.r_valid  = v.m_rv;
    mst_resp.r_last   = v.m_rl;
  endtask

  // Leaves rst_n released just after a falling edge.
  task automatic do_reset();
    clear();
    rst_n = 1'b0;
    #2;
    chk("reset outputs", 64'(sample()), 64'(Z));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    exp_t got;
    Z = '0;
    clear();

    // --- port 0 write (len 0) then read ---
    add("A0 idle", H, in_t'{2'b01,2'b01,2'b01,2'b01,2'b00,2'b00, H,H,L,L,L,L, 2'd0}, Z);
    add("A1 aw",   L, in_t'{2'b01,2'b01,2'b01,2'b01,2'b00,2'b00, H,H,L,L,L,L, 2'd0},
        exp_t'{2'b01,2'b00, H,L,L,L,L, 2'b01,2'b00,2'b00,2'b00,2'b00, L});
    add("A2 w",    L, in_t'{2'b00,2'b01,2'b01,2'b01,2'b00,2'b00, H,H,L,L,L,L, 2'd0},
        exp_t'{2'b01,2'b00, L,H,L,L,L, 2'b00,2'b01,2'b00,2'b00,2'b00, L});
    add("A3 b",    L, in_t'{2'b00,2'b00,2'b00,2'b01,2'b00,2'b00, H,H,H,L,L,L, 2'd0},
        exp_t'{2'b01,2'b00, L,L,H,L,L, 2'b00,2'b00,2'b01,2'b00,2'b00, L});
    add("A4 ridle",L, in_t'{2'b00,2'b00,2'b00,2'b00,2'b01,2'b01, L,L,L,H,L,L, 2'd0}, Z);
    add("A5 ar",   L, in_t'{2'b00,2'b00,2'b00,2'b00,2'b01,2'b01, L,L,L,H,L,L, 2'd0},
        exp_t'{2'b00,2'b01, L,L,L,H,L, 2'b00,2'b00,2'b00,2'b01,2'b00, L});
    add("A6 r",    L, in_t'{2'b00,2'b00,2'b00,2'b00,2'b00,2'b01, L,L,L,H,H,H, 2'd0},
        exp_t'{2'b00,2'b01, L,L,L,L,H, 2'b00,2'b00,2'b00,2'b00,2'b01, L});
    add("A7 done", L, in_t'(0), Z);

    // --- both ports contend three times: 0,1,0 ---
    for (int k = 0; k < 3; k++) begin
      logic [1:0] g;
      g = (k == 1) ? 2'b10 : 2'b01;
      add("B idle", (k == 0), in_t'{2'b11,2'b11,2'b11,2'b11,2'b00,2'b00, H,H,H,L,L,L, 2'd0}, Z);
      add("B aw",   L, in_t'{2'b11,2'b11,2'b11,2'b11,2'b00,2'b00, H,H,H,L,L,L, 2'd0},
          exp_t'{g,2'b00, H,L,L,L,L, g,2'b00,2'b00,2'b00,2'b00, L});
      if (k < 2) begin
        add("B w",  L, in_t'{2'b11,2'b11,2'b11,2'b11,2'b00,2'b00, H,H,H,L,L,L, 2'd0},
            exp_t'{g,2'b00, L,H,L,L,L, 2'b00,g,2'b00,2'b00,2'b00, L});
        add("B b",  L, in_t'{2'b11,2'b11,2'b11,2'b11,2'b00,2'b00, H,H,H,L,L,L, 2'd0},
            exp_t'{g,2'b00, L,L,H,L,L, 2'b00,2'b00,g,2'b00,2'b00, L});
      end
    end

    // --- port 1 4-beat write concurrent with port 0 4-beat read ---
    add("C0 idle", H, in_t'{2'b10,2'b10,2'b00,2'b10,2'b01,2'b01, H,H,L,H,L,L, 2'd3}, Z);
    add("C1 addr", L, in_t'{2'b10,2'b10,2'b00,2'b10,2'b01,2'b01, H,H,L,H,L,L, 2'd3},
        exp_t'{2'b10,2'b01, H,L,L,H,L, 2'b10,2'b00,2'b00,2'b01,2'b00, L});
    for (int k = 0; k < 4; k++)
      add("C data", L, in_t'{2'b00,2'b10,(k == 3) ? 2'b10 : 2'b00,2'b10,2'b00,2'b01,
                             H,H,L,H,H,(k == 3), 2'd3},
          exp_t'{2'b10,2'b01, L,H,L,L,H, 2'b00,2'b10,2'b00,2'b00,2'b01, L});
    add("C6 b",    L, in_t'{2'b00,2'b00,2'b00,2'b10,2'b00,2'b00, H,H,H,H,L,L, 2'd3},
        exp_t'{2'b10,2'b00, L,L,H,L,L, 2'b00,2'b00,2'b10,2'b00,2'b00, L});
    add("C7 done", L, in_t'(0), Z);

    // --- early wlast on beat 2 of awlen=3 ---
    add("D0 idle", H, in_t'{2'b01,2'b01,2'b00,2'b01,2'b00,2'b00, H,H,L,L,L,L, 2'd3}, Z);
    add("D1 aw",   L, in_t'{2'b01,2'b01,2'b00,2'b01,2'b00,2'b00, H,H,L,L,L,L, 2'd3},
        exp_t'{2'b01,2'b00, H,L,L,L,L, 2'b01,2'b00,2'b00,2'b00,2'b00, L});
    for (int k = 0; k < 3; k++)
      add("D beat", L, in_t'{2'b00,2'b01,(k == 2) ? 2'b01 : 2'b00,2'b01,2'b00,2'b00,
                             H,H,L,L,L,L, 2'd3},
          exp_t'{2'b01,2'b00, L,H,L,L,L, 2'b00,2'b01,2'b00,2'b00,2'b00, (k == 2)});
    add("D5 resp", L, in_t'{2'b00,2'b01,2'b00,2'b01,2'b00,2'b00, H,H,L,L,L,L, 2'd3},
        exp_t'{2'b01,2'b00, L,L,H,L,L, 2'b00,2'b00,2'b00,2'b00,2'b00, L});
    add("D6 b",    L, in_t'{2'b00,2'b00,2'b00,2'b01,2'b00,2'b00, H,H,H,L,L,L, 2'd3},
        exp_t'{2'b01,2'b00, L,L,H,L,L, 2'b00,2'b00,2'b01,2'b00,2'b00, L});
    add("D7 done", L, in_t'(0), Z);

    @(negedge clk);
    foreach (tbl[k]) begin
      if (tbl[k].rst) do_reset();
      apply(tbl[k].i);
      #2;
      got = sample();
      n_vec++;
      if (got !== tbl[k].e) begin
        n_bad++;
        $display("FAIL vec %0d %s: got %h want %h", k, tbl[k].nm, got, tbl[k].e);
      end
      @(negedge clk);
    end

    // --- payload: write 0x100 to 0x10A8, read it back ---
    do_reset();
    slv_req[0].aw_valid = 1'b1; slv_req[0].aw_addr = 32'h10A8; slv_req[0].aw_id = 4'h3;
    slv_req[0].w_valid  = 1'b1; slv_req[0].w_data  = 32'h100;  slv_req[0].w_strb = 4'hF;
    slv_req[0].w_last   = 1'b1; slv_req[0].b_ready = 1'b1;
    mst_resp.aw_ready = 1'b1; mst_resp.w_ready = 1'b1;
    @(negedge clk); #2;
    chk("wr aw_addr", mst_req.aw_addr, 64'h10A8);
    chk("wr aw_id", mst_req.aw_id, 64'h3);
    @(negedge clk); slv_req[0].aw_valid = 1'b0; #2;
    chk("wr w_data", {mst_req.w_valid, mst_req.w_data}, {1'b1, 32'h100});
    mem_word = mst_req.w_data;
    @(negedge clk); slv_req[0].w_valid = 1'b0;
    mst_resp.b_valid = 1'b1; mst_resp.b_resp = RESP_OKAY; mst_resp.b_id = 4'h3; #2;
    chk("wr b route", {slv_resp[0].b_valid, slv_resp[1].b_valid, slv_resp[0].b_resp, slv_resp[0].b_id},
        {1'b1, 1'b0, RESP_OKAY, 4'h3});
    @(negedge clk); mst_resp.b_valid = 1'b0; slv_req[0].b_ready = 1'b0;
    slv_req[0].ar_valid = 1'b1; slv_req[0].ar_addr = 32'h10A8; slv_req[0].r_ready = 1'b1;
    mst_resp.ar_ready = 1'b1; #2;
    chk("wr gnt released", wr_gnt, 64'h0);
    @(negedge clk); #2;
    chk("rd ar", {rd_gnt, mst_req.ar_valid, mst_req.ar_addr}, {2'b01, 1'b1, 32'h10A8});
    @(negedge clk); slv_req[0].ar_valid = 1'b0;
    mst_resp.r_valid = 1'b1; mst_resp.r_last = 1'b1; mst_resp.r_data = mem_word; #2;
    chk("rd data", {slv_resp[0].r_valid, slv_resp[1].r_valid, slv_resp[0].r_data},
        {1'b1, 1'b0, 32'h100});
    @(negedge clk); mst_resp.r_valid = 1'b0; #2;
    chk("rd gnt released", rd_gnt, 64'h0);

    // --- async reset in W_DATA beat 2, then a fresh port 1 write ---
    do_reset();
    slv_req[0].aw_valid = 1'b1; slv_req[0].aw_len = 8'd3; slv_req[0].w_valid = 1'b1;
    mst_resp.aw_ready = 1'b1; mst_resp.w_ready = 1'b1;
    @(negedge clk);
    @(negedge clk); slv_req[0].aw_valid = 1'b0;
    @(negedge clk);
    @(negedge clk); #2;
    chk("beat2 before rst", {wr_gnt, mst_req.w_valid}, {2'b01, 1'b1});
    rst_n = 1'b0; #1;
    chk("async rst gnts", {wr_gnt, rd_gnt, wlast_err}, 64'h0);
    chk("async rst mst", {mst_req.aw_valid, mst_req.w_valid, mst_req.b_ready,
                          mst_req.ar_valid, mst_req.r_ready}, 64'h0);
    chk("async rst slv", {slv_resp[0].w_ready, slv_resp[0].aw_ready, slv_resp[0].b_valid,
                          slv_resp[1].w_ready, slv_resp[1].aw_ready}, 64'h0);
    clear();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    slv_req[1].aw_valid = 1'b1; slv_req[1].aw_id = 4'h5; slv_req[1].aw_addr = 32'h2000;
    slv_req[1].w_valid  = 1'b1; slv_req[1].w_data = 32'hCAFE_F00D; slv_req[1].w_strb = 4'hF;
    slv_req[1].w_last   = 1'b1; slv_req[1].b_ready = 1'b1;
    mst_resp.aw_ready = 1'b1; mst_resp.w_ready = 1'b1; #2;
    chk("post-rst idle", {wr_gnt, mst_req.w_valid}, 64'h0);
    @(negedge clk); #2;
    chk("p1 aw", {wr_gnt, mst_req.aw_valid, mst_req.aw_id, mst_req.aw_addr,
                  slv_resp[1].aw_ready, slv_resp[0].aw_ready},
        {2'b10, 1'b1, 4'h5, 32'h2000, 1'b1, 1'b0});
    @(negedge clk); slv_req[1].aw_valid = 1'b0; #2;
    chk("p1 w", {mst_req.w_valid, mst_req.w_data, slv_resp[1].w_ready},
        {1'b1, 32'hCAFE_F00D, 1'b1});
    @(negedge clk); slv_req[1].w_valid = 1'b0;
    mst_resp.b_valid = 1'b1; mst_resp.b_id = 4'h5; #2;
    chk("p1 b", {slv_resp[1].b_valid, slv_resp[0].b_valid, slv_resp[1].b_id},
        {1'b1, 1'b0, 4'h5});
    @(negedge clk); mst_resp.b_valid = 1'b0; #2;
    chk("p1 done", {wr_gnt, mst_req.w_valid, mst_req.b_ready}, 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
